// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - multi-mode shift/rotate/load register with autonomous burst engine
module univ_shift_reg #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;
    localparam logic [2:0] MODE_ASR  = 3'b111;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] q_r;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_r;

    // Next register value for a given operation; shared by single-step and burst paths
    function automatic logic [WIDTH-1:0] next_q(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] din,
        input logic             sr,
        input logic             sl
    );
        logic [WIDTH-1:0] r;
        r = cur;
        case (op)
            MODE_HOLD: r = cur;
            MODE_SHR:  r = {sr, cur[WIDTH-1:1]};
            MODE_SHL:  r = {cur[WIDTH-2:0], sl};
            MODE_ROR:  r = {cur[0], cur[WIDTH-1:1]};
            MODE_ROL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_LOAD: r = din;
            MODE_CLR:  r = '0;
            MODE_ASR:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default:   r = cur;
        endcase
        return r;
    endfunction

    // Only pure shift/rotate operations are meaningful to repeat in a burst
    function automatic logic is_burst_op(input logic [2:0] op);
        return (op == MODE_SHR) || (op == MODE_SHL) || (op == MODE_ROR) ||
               (op == MODE_ROL) || (op == MODE_ASR);
    endfunction

    // Control FSM and data register; busy/done are registered alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            q_r   <= RST_VAL;
            cnt   <= '0;
            op_r  <= MODE_HOLD;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // q is left untouched on the start edge either way
                        if ((amount != '0) && is_burst_op(mode)) begin
                            op_r  <= mode;
                            cnt   <= amount;
                            state <= BUSY;
                            busy  <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end else if (en) begin
                        q_r <= next_q(mode, q_r, d, sin_r, sin_l);
                    end
                end
                BUSY: begin
                    // Serial inputs are sampled live each step; d is irrelevant to burst ops
                    q_r <= next_q(op_r, q_r, d, sin_r, sin_l);
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Derived outputs are purely combinational views of the register
    always_comb begin
        q      = q_r;
        qbar   = ~q_r;
        sout_r = q_r[0];
        sout_l = q_r[WIDTH-1];
    end

endmodule
